// File: rtl/regfile_read_arbiter_pkg.sv
// Shared constants and state encoding for the register-file read arbiter.
package regfile_arb_pkg;

    localparam int DEFAULT_ADDR_W = 5;
    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } arb_state_t;

    // Index width for a requester number; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_read_arbiter_if.sv
// Requester-facing request/response channels of the register-file read arbiter.
interface regfile_read_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_rs1;
    logic [NUM_REQ*ADDR_W-1:0] req_rs2;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [NUM_REQ-1:0]        rsp_ready;
    logic [DATA_W-1:0]         rsp_rs1_data;
    logic [DATA_W-1:0]         rsp_rs2_data;

    modport master (
        output req_valid, req_rs1, req_rs2, rsp_ready,
        input  req_ready, rsp_valid, rsp_rs1_data, rsp_rs2_data
    );

    modport slave (
        input  req_valid, req_rs1, req_rs2, rsp_ready,
        output req_ready, rsp_valid, rsp_rs1_data, rsp_rs2_data
    );
endinterface

// File: rtl/regfile_read_arbiter_rr_arbiter.sv
// Round-robin selector: first valid request strictly after rr_ptr, wrapping.
module rr_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]             req,
    input  logic [idx_width(NUM_REQ)-1:0]  rr_ptr,
    input  logic                           enable,
    output logic [NUM_REQ-1:0]             grant,
    output logic [idx_width(NUM_REQ)-1:0]  grant_idx,
    output logic                           grant_valid
);
    localparam int IDX_W = idx_width(NUM_REQ);

    int idx;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (enable && !grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant[idx]  = 1'b1;
                grant_idx   = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares the register file's registered read ports between NUM_REQ requesters,
// one read in flight, one read per cycle when responses are always accepted.
module regfile_read_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DATA_W  = DEFAULT_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_read_arbiter_if.slave bus,
    output logic                  rf_rd_enable,
    output logic [ADDR_W-1:0]     rf_rs1,
    output logic [ADDR_W-1:0]     rf_rs2,
    input  logic [DATA_W-1:0]     rf_rs1_data,
    input  logic [DATA_W-1:0]     rf_rs2_data
);
    localparam int IDX_W = idx_width(NUM_REQ);

    arb_state_t          state;
    arb_state_t          state_next;
    logic [IDX_W-1:0]    owner;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    grant_idx;
    logic [NUM_REQ-1:0]  grant;
    logic                fire;
    logic                owner_ready;
    logic                can_issue;

    assign owner_ready = bus.rsp_ready[owner];
    assign can_issue   = !rst && ((state == IDLE) || (state == RESP && owner_ready));

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req         (bus.req_valid),
        .rr_ptr      (rr_ptr),
        .enable      (can_issue),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (fire)
    );

    assign bus.req_ready = grant;

    always_comb begin
        rf_rd_enable = fire;
        rf_rs1       = '0;
        rf_rs2       = '0;
        if (fire) begin
            rf_rs1 = bus.req_rs1[int'(grant_idx)*ADDR_W +: ADDR_W];
            rf_rs2 = bus.req_rs2[int'(grant_idx)*ADDR_W +: ADDR_W];
        end
    end

    // The register file holds its outputs while enable is low, so the data
    // path is a straight pass-through qualified by rsp_valid.
    always_comb begin
        bus.rsp_valid = '0;
        if (state == RESP && !rst)
            bus.rsp_valid[owner] = 1'b1;
    end

    assign bus.rsp_rs1_data = rf_rs1_data;
    assign bus.rsp_rs2_data = rf_rs2_data;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (fire) state_next = RESP;
            RESP: begin
                if (fire)
                    state_next = RESP;
                else if (owner_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= IDX_W'(NUM_REQ - 1);
        end else begin
            state <= state_next;
            if (fire) begin
                owner  <= grant_idx;
                rr_ptr <= grant_idx;
            end
        end
    end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter with two- and three-requester instances
// behind a register file holding entry i = i*4679.
module tb_regfile_read_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    regfile_read_arbiter_if #(.NUM_REQ(2), .ADDR_W(AW), .DATA_W(DW)) a_if ();
    regfile_read_arbiter_if #(.NUM_REQ(3), .ADDR_W(AW), .DATA_W(DW)) b_if ();

    logic          a_en, b_en;
    logic [AW-1:0] a_rs1, a_rs2, b_rs1, b_rs2;
    logic [DW-1:0] a_d1, a_d2, b_d1, b_d2;

    regfile_read_arbiter #(.NUM_REQ(2), .ADDR_W(AW), .DATA_W(DW)) dut_a (
        .clk (clk), .rst (rst), .bus (a_if),
        .rf_rd_enable (a_en), .rf_rs1 (a_rs1), .rf_rs2 (a_rs2),
        .rf_rs1_data (a_d1), .rf_rs2_data (a_d2)
    );

    regfile_read_arbiter #(.NUM_REQ(3), .ADDR_W(AW), .DATA_W(DW)) dut_b (
        .clk (clk), .rst (rst), .bus (b_if),
        .rf_rd_enable (b_en), .rf_rs1 (b_rs1), .rf_rs2 (b_rs2),
        .rf_rs1_data (b_d1), .rf_rs2_data (b_d2)
    );

    function automatic logic [DW-1:0] rf_val(input logic [AW-1:0] a);
        return DW'(a) * 32'd4679;
    endfunction

    // Registered read ports that hold their value while enable is low.
    always_ff @(posedge clk) begin
        if (a_en) begin
            a_d1 <= rf_val(a_rs1);
            a_d2 <= rf_val(a_rs2);
        end
        if (b_en) begin
            b_d1 <= rf_val(b_rs1);
            b_d2 <= rf_val(b_rs2);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        a_if.req_valid = '0; a_if.req_rs1 = '0; a_if.req_rs2 = '0; a_if.rsp_ready = '0;
        b_if.req_valid = '0; b_if.req_rs1 = '0; b_if.req_rs2 = '0; b_if.rsp_ready = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        rst = 1'b1;
        tick();
        total++; if (a_if.rsp_valid !== 2'b00) begin bad++; $display("[TB] FAIL reset_rsp_valid got=%b want=00", a_if.rsp_valid); end
        total++; if (a_if.req_ready !== 2'b00) begin bad++; $display("[TB] FAIL reset_req_ready got=%b want=00", a_if.req_ready); end
        total++; if (a_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_rf_en got=%b want=0", a_en); end
        total++; if (a_rs1 !== 5'd0 || a_rs2 !== 5'd0) begin bad++; $display("[TB] FAIL reset_rf_addr got=%0d/%0d want=0/0", a_rs1, a_rs2); end
        total++; if (b_if.rsp_valid !== 3'b000) begin bad++; $display("[TB] FAIL reset_b_rsp_valid got=%b want=000", b_if.rsp_valid); end
        rst = 1'b0;
    endtask

    task automatic test_single_read;
        a_if.req_rs1 = {5'd0, 5'd3};
        a_if.req_rs2 = {5'd0, 5'd5};
        a_if.rsp_ready = 2'b11;
        a_if.req_valid = 2'b01;
        #1;
        total++; if (a_if.req_ready !== 2'b01) begin bad++; $display("[TB] FAIL single_grant got=%b want=01", a_if.req_ready); end
        total++; if (a_en !== 1'b1 || a_rs1 !== 5'd3 || a_rs2 !== 5'd5) begin bad++; $display("[TB] FAIL single_rf got=%b/%0d/%0d want=1/3/5", a_en, a_rs1, a_rs2); end
        tick();
        a_if.req_valid = 2'b00;
        #1;
        total++; if (a_if.rsp_valid !== 2'b01) begin bad++; $display("[TB] FAIL single_rsp_valid got=%b want=01", a_if.rsp_valid); end
        total++; if (a_if.rsp_rs1_data !== 32'd14037 || a_if.rsp_rs2_data !== 32'd23395) begin bad++; $display("[TB] FAIL single_data got=%0d/%0d want=14037/23395", a_if.rsp_rs1_data, a_if.rsp_rs2_data); end
        tick();
        total++; if (a_if.rsp_valid !== 2'b00) begin bad++; $display("[TB] FAIL single_idle got=%b want=00", a_if.rsp_valid); end
    endtask

    task automatic test_zero_reg;
        a_if.req_rs1 = {5'd0, 5'd3};
        a_if.req_rs2 = {5'd31, 5'd5};
        a_if.req_valid = 2'b10;
        #1;
        total++; if (a_if.req_ready !== 2'b10) begin bad++; $display("[TB] FAIL zero_grant got=%b want=10", a_if.req_ready); end
        tick();
        a_if.req_valid = 2'b00;
        #1;
        total++; if (a_if.rsp_valid !== 2'b10) begin bad++; $display("[TB] FAIL zero_rsp_valid got=%b want=10", a_if.rsp_valid); end
        total++; if (a_if.rsp_rs1_data !== 32'd0 || a_if.rsp_rs2_data !== 32'd145049) begin bad++; $display("[TB] FAIL zero_data got=%0d/%0d want=0/145049", a_if.rsp_rs1_data, a_if.rsp_rs2_data); end
        tick();
    endtask

    task automatic test_back_to_back;
        logic [1:0]    exp_g;
        logic [1:0]    prev_g;
        logic [DW-1:0] exp_d1;
        logic [DW-1:0] exp_d2;
        do_reset();
        prev_g = 2'b00;
        a_if.req_rs1 = {5'd10, 5'd1};
        a_if.req_rs2 = {5'd20, 5'd2};
        a_if.rsp_ready = 2'b11;
        a_if.req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            #1;
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            total++; if (a_if.req_ready !== exp_g || a_en !== 1'b1) begin bad++; $display("[TB] FAIL b2b_grant[%0d] got=%b en=%b want=%b en=1", k, a_if.req_ready, a_en, exp_g); end
            if (k > 0) begin
                exp_d1 = (prev_g == 2'b01) ? 32'd4679 : 32'd46790;
                exp_d2 = (prev_g == 2'b01) ? 32'd9358 : 32'd93580;
                total++; if (a_if.rsp_valid !== prev_g || a_if.rsp_rs1_data !== exp_d1 || a_if.rsp_rs2_data !== exp_d2) begin
                    bad++; $display("[TB] FAIL b2b_rsp[%0d] got=%b %0d/%0d want=%b %0d/%0d", k, a_if.rsp_valid, a_if.rsp_rs1_data, a_if.rsp_rs2_data, prev_g, exp_d1, exp_d2);
                end
            end
            prev_g = exp_g;
            tick();
        end
        a_if.req_valid = 2'b00;
        tick();
    endtask

    task automatic test_backpressure;
        do_reset();
        a_if.req_rs1 = {5'd11, 5'd7};
        a_if.req_rs2 = {5'd12, 5'd9};
        a_if.rsp_ready = 2'b00;
        a_if.req_valid = 2'b11;
        #1;
        total++; if (a_if.req_ready !== 2'b01) begin bad++; $display("[TB] FAIL bp_first_grant got=%b want=01", a_if.req_ready); end
        tick();
        a_if.req_valid = 2'b10;
        a_if.rsp_ready = 2'b10;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (a_if.rsp_valid !== 2'b01 || a_if.rsp_rs1_data !== 32'd32753 || a_if.rsp_rs2_data !== 32'd42111) begin
                bad++; $display("[TB] FAIL bp_hold[%0d] got=%b %0d/%0d want=01 32753/42111", c, a_if.rsp_valid, a_if.rsp_rs1_data, a_if.rsp_rs2_data);
            end
            total++; if (a_if.req_ready !== 2'b00 || a_en !== 1'b0) begin bad++; $display("[TB] FAIL bp_stall[%0d] got=%b en=%b want=00 en=0", c, a_if.req_ready, a_en); end
            tick();
        end
        a_if.rsp_ready = 2'b11;
        #1;
        total++; if (a_if.req_ready !== 2'b10 || a_en !== 1'b1 || a_rs1 !== 5'd11) begin bad++; $display("[TB] FAIL bp_release got=%b en=%b rs1=%0d want=10 en=1 rs1=11", a_if.req_ready, a_en, a_rs1); end
        tick();
        a_if.req_valid = 2'b00;
        #1;
        total++; if (a_if.rsp_valid !== 2'b10 || a_if.rsp_rs1_data !== 32'd51469 || a_if.rsp_rs2_data !== 32'd56148) begin
            bad++; $display("[TB] FAIL bp_second_rsp got=%b %0d/%0d want=10 51469/56148", a_if.rsp_valid, a_if.rsp_rs1_data, a_if.rsp_rs2_data);
        end
        tick();
    endtask

    task automatic test_reset_in_resp;
        do_reset();
        a_if.req_rs1 = {5'd4, 5'd2};
        a_if.req_rs2 = {5'd4, 5'd2};
        a_if.rsp_ready = 2'b11;
        a_if.req_valid = 2'b01;
        tick();
        a_if.req_valid = 2'b10;
        #1;
        total++; if (a_if.req_ready !== 2'b10) begin bad++; $display("[TB] FAIL rir_setup got=%b want=10", a_if.req_ready); end
        tick();
        a_if.rsp_ready = 2'b00;
        a_if.req_valid = 2'b11;
        rst = 1'b1;
        tick();
        total++; if (a_if.rsp_valid !== 2'b00 || a_if.req_ready !== 2'b00) begin bad++; $display("[TB] FAIL rir_cleared got=%b/%b want=00/00", a_if.rsp_valid, a_if.req_ready); end
        rst = 1'b0;
        #1;
        total++; if (a_if.req_ready !== 2'b01) begin bad++; $display("[TB] FAIL rir_first_grant got=%b want=01", a_if.req_ready); end
        a_if.req_valid = 2'b00;
        tick();
    endtask

    task automatic test_three_req;
        do_reset();
        b_if.req_rs1 = {5'd3, 5'd2, 5'd1};
        b_if.req_rs2 = {5'd6, 5'd5, 5'd4};
        b_if.rsp_ready = 3'b111;
        b_if.req_valid = 3'b010;
        #1;
        total++; if (b_if.req_ready !== 3'b010 || b_en !== 1'b1 || b_rs1 !== 5'd2) begin bad++; $display("[TB] FAIL three_alone got=%b en=%b rs1=%0d want=010 en=1 rs1=2", b_if.req_ready, b_en, b_rs1); end
        tick();
        b_if.req_valid = 3'b111;
        #1;
        total++; if (b_if.rsp_valid !== 3'b010 || b_if.rsp_rs1_data !== 32'd9358 || b_if.rsp_rs2_data !== 32'd23395) begin
            bad++; $display("[TB] FAIL three_rsp1 got=%b %0d/%0d want=010 9358/23395", b_if.rsp_valid, b_if.rsp_rs1_data, b_if.rsp_rs2_data);
        end
        total++; if (b_if.req_ready !== 3'b100) begin bad++; $display("[TB] FAIL three_next2 got=%b want=100", b_if.req_ready); end
        tick();
        total++; if (b_if.rsp_valid !== 3'b100 || b_if.rsp_rs1_data !== 32'd14037) begin bad++; $display("[TB] FAIL three_rsp2 got=%b %0d want=100 14037", b_if.rsp_valid, b_if.rsp_rs1_data); end
        total++; if (b_if.req_ready !== 3'b001) begin bad++; $display("[TB] FAIL three_wrap got=%b want=001", b_if.req_ready); end
        tick();
        total++; if (b_if.rsp_valid !== 3'b001 || b_if.rsp_rs1_data !== 32'd4679 || b_if.rsp_rs2_data !== 32'd18716) begin
            bad++; $display("[TB] FAIL three_rsp0 got=%b %0d/%0d want=001 4679/18716", b_if.rsp_valid, b_if.rsp_rs1_data, b_if.rsp_rs2_data);
        end
        total++; if (b_if.req_ready !== 3'b010) begin bad++; $display("[TB] FAIL three_next1 got=%b want=010", b_if.req_ready); end
        b_if.req_valid = 3'b000;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_zero_reg();
        test_back_to_back();
        test_backpressure();
        test_reset_in_resp();
        test_three_req();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
